// File: rtl/lcd_page_arbiter.sv
// lcd_page_arbiter
// Shares one 2x16 character LCD between three screen sources:
//   page 0 = clock display, page 1 = setting menu, page 2 = alarm message.
// Ownership uses fixed priority (2 > 1 > 0). A higher-priority source can
// take the display only after the owner has held it for MIN_HOLD cycles.
// Releasing the display is immediate. Each owner can ask for its screen to
// blink with a half-period of BLINK_HALF cycles. All outputs are registered.
module lcd_page_arbiter #(
  parameter int MIN_HOLD   = 50_000_000,
  parameter int BLINK_HALF = 25_000_000,
  parameter int HOLD_W     = 26
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [2:0]   blink,
  input  logic [255:0] page0,
  input  logic [255:0] page1,
  input  logic [255:0] page2,
  output logic [2:0]   grant,
  output logic [255:0] chars,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2,
    S_OWN2 = 2'd3
  } state_e;

  localparam logic [255:0]      BLANK      = {32{8'h20}};
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(MIN_HOLD);
  localparam logic [HOLD_W-1:0] BLINK_LAST = HOLD_W'(BLINK_HALF - 1);
  localparam logic [HOLD_W-1:0] CNT_ONE    = HOLD_W'(1);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HOLD_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [2:0]          grant_q, grant_d;
  logic [255:0]        chars_q, chars_d;
  logic                busy_q, busy_d;

  logic                hold_full;
  logic                owner_change;

  // Highest-priority active requester, or IDLE when nobody asks.
  function automatic state_e top_req(input logic [2:0] r);
    if (r[2])      return S_OWN2;
    else if (r[1]) return S_OWN1;
    else if (r[0]) return S_OWN0;
    else           return S_IDLE;
  endfunction

  assign hold_full = (hold_q == HOLD_MAX);

  // Next owner: release is immediate, preemption waits for a full hold.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch
    // can be inferred on paths that do not assign it.
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = top_req(req);
      S_OWN0: begin
        if (!req[0])                      state_d = top_req(req);
        else if (|req[2:1] && hold_full)  state_d = top_req(req);
      end
      S_OWN1: begin
        if (!req[1])                      state_d = top_req(req);
        else if (req[2] && hold_full)     state_d = S_OWN2;
      end
      S_OWN2: begin
        if (!req[2])                      state_d = top_req(req);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign owner_change = (state_d != state_q);

  // Hold and blink timers restart on every owner change and idle in IDLE.
  always_comb begin
    hold_d      = hold_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (owner_change || state_q == S_IDLE) begin
      hold_d      = '0;
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else begin
      if (!hold_full) hold_d = hold_q + CNT_ONE;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_ONE;
      end
    end
  end

  // Output image follows the next-state owner, blanked on its off phase.
  always_comb begin
    grant_d = 3'b000;
    chars_d = BLANK;
    case (state_d)
      S_OWN0: begin
        grant_d = 3'b001;
        chars_d = (blink[0] && phase_d) ? BLANK : page0;
      end
      S_OWN1: begin
        grant_d = 3'b010;
        chars_d = (blink[1] && phase_d) ? BLANK : page1;
      end
      S_OWN2: begin
        grant_d = 3'b100;
        chars_d = (blink[2] && phase_d) ? BLANK : page2;
      end
      default: begin
        grant_d = 3'b000;
        chars_d = BLANK;
      end
    endcase
    busy_d = |grant_d;
  end

  // State, timers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      grant_q     <= 3'b000;
      chars_q     <= BLANK;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q     <= state_d;
      hold_q      <= hold_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      grant_q     <= grant_d;
      chars_q     <= chars_d;
      busy_q      <= busy_d;
    end
  end

  assign grant = grant_q;
  assign chars = chars_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_lcd_page_arbiter.sv
// Testbench for lcd_page_arbiter: directed scenarios plus randomized
// traffic, every cycle compared against a cycles-since-grant reference model.
module tb_lcd_page_arbiter;

  localparam int MIN_HOLD   = 8;
  localparam int BLINK_HALF = 4;
  localparam int HOLD_W     = 26;
  localparam logic [255:0] BLANK = {32{8'h20}};

  logic         clk;
  logic         rst;
  logic [2:0]   req;
  logic [2:0]   blink;
  logic [255:0] pg [3];
  logic [2:0]   grant;
  logic [255:0] chars;
  logic         busy;

  int n_checks;
  int n_fail;

  // Reference model: owner index (-1 = idle) and cycles since it was granted.
  int m_owner;
  int m_elapsed;

  lcd_page_arbiter #(
    .MIN_HOLD  (MIN_HOLD),
    .BLINK_HALF(BLINK_HALF),
    .HOLD_W    (HOLD_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .blink(blink),
    .page0(pg[0]),
    .page1(pg[1]),
    .page2(pg[2]),
    .grant(grant),
    .chars(chars),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] text(input string s);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) begin
      r[255 - 8*i -: 8] = (i < s.len()) ? s[i] : 8'h20;
    end
    return r;
  endfunction

  function automatic int highest(input logic [2:0] r);
    for (int i = 2; i >= 0; i--) if (r[i]) return i;
    return -1;
  endfunction

  function automatic logic [255:0] rand_page();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_elapsed = 0;
  endtask

  // One clock: advance the model on the pre-edge inputs, then compare.
  task automatic tick();
    int h, nxt;
    logic [2:0]   eg;
    logic [255:0] ec;
    h = highest(req);
    if (m_owner < 0 || !req[m_owner]) nxt = h;
    else if (h > m_owner && m_elapsed >= MIN_HOLD) nxt = h;
    else nxt = m_owner;
    if (nxt != m_owner) m_elapsed = 0;
    else if (nxt >= 0) m_elapsed++;
    m_owner = nxt;
    if (m_owner < 0) begin
      eg = 3'b000;
      ec = BLANK;
    end else begin
      eg = 3'(1 << m_owner);
      if (blink[m_owner] && ((m_elapsed / BLINK_HALF) % 2 == 1)) ec = BLANK;
      else ec = pg[m_owner];
    end
    @(posedge clk);
    #1;
    check("grant", grant, eg);
    check("busy", busy, eg != 3'b000);
    check("chars", chars, ec);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    req   = 3'b000;
    blink = 3'b000;
    pg[0] = text("12:00:00 AM");
    pg[1] = text("SET ALARM 07:30");
    pg[2] = text("WAKE UP!");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_chars", chars, BLANK);
    rst = 1'b0;

    // Single requester gets the display and keeps it.
    req = 3'b001;
    tick();
    check("dir_grant0", grant, 3'b001);
    check("dir_chars0", chars, pg[0]);
    repeat (20) tick();
    check("dir_hold0", grant, 3'b001);

    // Preemption waits for the minimum hold.
    req = 3'b000;
    tick();
    req = 3'b001;
    tick();
    repeat (2) tick();
    req = 3'b101;
    n = 0;
    while (grant != 3'b100 && n < 30) begin
      tick();
      n++;
    end
    check("preempt_wait", n, 7);
    check("preempt_chars", chars, pg[2]);

    // Release needs no hold; then go idle.
    req = 3'b111;
    repeat (2) tick();
    req = 3'b011;
    tick();
    check("release_to1", grant, 3'b010);
    req = 3'b000;
    tick();
    check("idle_grant", grant, 3'b000);
    check("idle_busy", busy, 1'b0);
    check("idle_chars", chars, BLANK);

    // Blink: 4 cycles visible, 4 blank, starting visible at grant.
    req   = 3'b010;
    blink = 3'b010;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("blink_seq", chars, ((i / 4) % 2 == 0) ? pg[1] : BLANK);
    end
    blink = 3'b000;
    repeat (3) begin
      tick();
      check("blink_off", chars, pg[1]);
    end

    // Simultaneous requests from idle, then asynchronous reset mid-cycle.
    req = 3'b000;
    tick();
    req = 3'b011;
    tick();
    check("simul_grant", grant, 3'b010);
    #3;
    rst = 1'b1;
    #1;
    check("async_grant", grant, 3'b000);
    check("async_busy", busy, 1'b0);
    check("async_chars", chars, BLANK);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic with page content changing while owned.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req = 3'($urandom);
      if ($urandom_range(15) == 0) blink = 3'($urandom);
      if ($urandom_range(3) == 0) pg[$urandom_range(2)] = rand_page();
      if (c == 1500) begin
        #2;
        rst = 1'b1;
        #1;
        check("rand_rst_grant", grant, 3'b000);
        check("rand_rst_chars", chars, BLANK);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
